mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, MEM-stage and shared-SRAM signals of the memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the environment, which holds the requesters and the SRAM.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;
  logic        freeze;
  logic        err;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_rdata, sram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr,
           sram_wdata, freeze, err
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_rdata, sram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr,
           sram_wdata, freeze, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one SRAM port. The arbiter favours MEM, but when both requesters were waiting and MEM won last time, IF wins.
// Latency: grant -> ack -> one-cycle ready, with the next grant possible one cycle later. A requester stalls through freeze until its ready arrives.
module mem_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, if_rdata_q, mem_rdata_q, rdata_nxt;
  logic [CW-1:0] cnt_q;
  logic        we_q, is_mem_q, last_mem_q, err_q;
  logic        mem_pend, in_acc, gnt_if, gnt_mem, done, abort;

  assign mem_pend = bus.mem_rd | bus.mem_wr;
  assign in_acc   = (state_q == IF_ACC) || (state_q == MEM_ACC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        // MEM wins unless it also won last time and IF is waiting too
        if (mem_pend && !(bus.if_req && last_mem_q)) begin
          gnt_mem = 1'b1;
          state_d = MEM_ACC;
        end else if (bus.if_req) begin
          gnt_if  = 1'b1;
          state_d = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (bus.sram_ack) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rdata_nxt = abort ? ERR_DATA : bus.sram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      is_mem_q    <= 1'b0;
      last_mem_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (gnt_if || gnt_mem) begin
        addr_q     <= gnt_mem ? bus.mem_addr : bus.if_addr;
        wdata_q    <= gnt_mem ? bus.mem_wdata : '0;
        we_q       <= gnt_mem & bus.mem_wr;
        is_mem_q   <= gnt_mem;
        last_mem_q <= gnt_mem;
        cnt_q      <= '0;
        // A request that is both a load and a store runs as a store and is flagged
        if (gnt_mem && bus.mem_rd && bus.mem_wr) err_q <= 1'b1;
      end
      if (in_acc) cnt_q <= (done || abort) ? '0 : cnt_q + 1'b1;
      if (abort) err_q <= 1'b1;
      if ((done || abort) && !we_q) begin
        if (is_mem_q) mem_rdata_q <= rdata_nxt;
        else          if_rdata_q  <= rdata_nxt;
      end
    end
  end

  assign bus.sram_en    = in_acc;
  assign bus.sram_we    = (state_q == MEM_ACC) && we_q;
  assign bus.sram_addr  = in_acc ? addr_q  : '0;
  assign bus.sram_wdata = in_acc ? wdata_q : '0;
  assign bus.if_ready   = (state_q == RESP) && !is_mem_q;
  assign bus.mem_ready  = (state_q == RESP) && is_mem_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.err        = err_q;
  assign bus.freeze     = (bus.if_req & ~bus.if_ready) | (mem_pend & ~bus.mem_ready);

endmodule
